// File: rtl/key_debounce_pulse.sv
// Push-button conditioner: 2-flop sync, debounce FSM, registered press/release pulses
// and optional auto-repeat of press_pulse while the key is held.
module key_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_DELAY    = 0,
  parameter int unsigned REPEAT_RATE     = 250_000
) (
  input  logic CLOCK_50,
  input  logic KEY0,
  input  logic btn_n,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] RPT_DELAY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_RATE  = CNT_W'(REPEAT_RATE);
  localparam bit               RPT_EN    = (REPEAT_DELAY != 0);

  logic             s1, s2;
  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic [CNT_W-1:0] rpt, rpt_d, rpt_inc, rpt_target;
  logic             rpt_first, rpt_first_d;
  logic             level_d, press_d, release_d;

  // Saturating increments; the first repeat interval is REPEAT_DELAY, later ones REPEAT_RATE.
  assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  assign rpt_inc    = (rpt == CNT_MAX) ? rpt : rpt + CNT_ONE;
  assign rpt_target = rpt_first ? RPT_DELAY : RPT_RATE;

  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      s1            <= 1'b1;
      s2            <= 1'b1;
      state         <= IDLE;
      cnt           <= '0;
      rpt           <= '0;
      rpt_first     <= 1'b1;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1            <= btn_n;
      s2            <= s1;
      state         <= state_d;
      cnt           <= cnt_d;
      rpt           <= rpt_d;
      rpt_first     <= rpt_first_d;
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    rpt_d       = rpt;
    rpt_first_d = rpt_first;
    level_d     = btn_level;
    press_d     = 1'b0;
    release_d   = 1'b0;
    case (state)
      IDLE: begin
        if (!s2) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (s2) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d     = HELD;
          level_d     = 1'b1;
          press_d     = 1'b1;
          cnt_d       = '0;
          rpt_d       = '0;
          rpt_first_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (s2) begin
          state_d     = REL_WAIT;
          cnt_d       = CNT_ONE;
          rpt_d       = '0;
          rpt_first_d = 1'b1;
        end else if (RPT_EN) begin
          if (rpt_inc == rpt_target) begin
            press_d     = 1'b1;
            rpt_d       = '0;
            rpt_first_d = 1'b0;
          end else begin
            rpt_d = rpt_inc;
          end
        end
      end
      REL_WAIT: begin
        // A glitch back to pressed returns to HELD and restarts the full repeat delay.
        if (!s2) begin
          state_d     = HELD;
          cnt_d       = '0;
          rpt_d       = '0;
          rpt_first_d = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Scoreboard bench for key_debounce_pulse: one instance without and one with auto-repeat,
// both driven by the same button/reset stimulus and checked against a run-length model.
module tb_key_debounce_pulse;

  localparam int D   = 4;
  localparam int RD0 = 0;
  localparam int RR0 = 250000;
  localparam int RD1 = 10;
  localparam int RR1 = 4;

  logic CLOCK_50 = 1'b0;
  logic KEY0;
  logic btn_n;
  logic lvl0, pp0, rp0;
  logic lvl1, pp1, rp1;
  logic [3:0] ledg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit run_mon = 1'b0;

  typedef struct {
    int edge_no;
    bit is_press;
  } pulse_t;

  pulse_t q0[$];
  pulse_t q1[$];

  bit m_s1[2];
  bit m_s2[2];
  bit m_lvl[2];
  int m_run[2];
  int m_h[2];

  always #10 CLOCK_50 = ~CLOCK_50;

  key_debounce_pulse #(.DEBOUNCE_CYCLES(D), .CNT_W(20), .REPEAT_DELAY(RD0), .REPEAT_RATE(RR0)) dut0 (
    .CLOCK_50(CLOCK_50), .KEY0(KEY0), .btn_n(btn_n),
    .btn_level(lvl0), .press_pulse(pp0), .release_pulse(rp0));

  key_debounce_pulse #(.DEBOUNCE_CYCLES(D), .CNT_W(20), .REPEAT_DELAY(RD1), .REPEAT_RATE(RR1)) dut1 (
    .CLOCK_50(CLOCK_50), .KEY0(KEY0), .btn_n(btn_n),
    .btn_level(lvl1), .press_pulse(pp1), .release_pulse(rp1));

  // Up-counter fed by press_pulse, standing in for the downstream LEDG counter.
  always @(posedge CLOCK_50) begin
    if (!KEY0) ledg <= 4'd0;
    else if (pp0) ledg <= ledg + 4'd1;
  end

  task automatic push_exp(input int inst, input int e, input bit pr);
    pulse_t p;
    p.edge_no  = e;
    p.is_press = pr;
    if (inst == 0) q0.push_back(p);
    else q1.push_back(p);
  endtask

  task automatic pop_exp(input int inst, output bit have, output pulse_t p);
    have = 1'b0;
    p.edge_no = -1;
    p.is_press = 1'b0;
    if (inst == 0 && q0.size() > 0) begin p = q0.pop_front(); have = 1'b1; end
    if (inst == 1 && q1.size() > 0) begin p = q1.pop_front(); have = 1'b1; end
  endtask

  function automatic int front_edge(input int inst);
    if (inst == 0) return (q0.size() > 0) ? q0[0].edge_no : 32'h7fffffff;
    return (q1.size() > 0) ? q1[0].edge_no : 32'h7fffffff;
  endfunction

  // Reference: a level flips after D consecutive synchronized samples disagreeing with it;
  // while pressed and undisturbed, repeats fire at held count RD and every RR after.
  always @(posedge CLOCK_50) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      bit old_s2;
      bit contrary;
      int rdl;
      int rrl;
      rdl = (i == 0) ? RD0 : RD1;
      rrl = (i == 0) ? RR0 : RR1;
      if (!KEY0) begin
        m_s1[i] = 1'b1; m_s2[i] = 1'b1; m_lvl[i] = 1'b0; m_run[i] = 0; m_h[i] = 0;
      end else begin
        old_s2   = m_s2[i];
        m_s2[i]  = m_s1[i];
        m_s1[i]  = btn_n;
        contrary = ((!old_s2) != m_lvl[i]);
        if (contrary) begin
          if (m_lvl[i] && m_run[i] == 0) m_h[i] = 0;
          m_run[i]++;
          if (m_run[i] == D) begin
            m_lvl[i] = !m_lvl[i];
            m_run[i] = 0;
            m_h[i]   = 0;
            push_exp(i, cyc, m_lvl[i]);
          end
        end else if (m_run[i] != 0) begin
          m_run[i] = 0;
          m_h[i]   = 0;
        end else if (m_lvl[i] && rdl > 0) begin
          m_h[i]++;
          if (m_h[i] == rdl || (m_h[i] > rdl && (m_h[i] - rdl) % rrl == 0))
            push_exp(i, cyc, 1'b1);
        end
      end
    end
  end

  task automatic check_inst(input int inst, input bit lvl, input bit pp, input bit rp);
    pulse_t p;
    bit have;
    checks++;
    if (lvl !== m_lvl[inst]) begin
      errors++;
      $display("FAIL level[%0d] edge %0d: got %0b want %0b", inst, cyc, lvl, m_lvl[inst]);
    end
    if (pp && rp) begin
      checks++;
      errors++;
      $display("FAIL both_pulses[%0d] edge %0d: press and release high together", inst, cyc);
    end
    if (pp || rp) begin
      checks++;
      pop_exp(inst, have, p);
      if (!have) begin
        errors++;
        $display("FAIL unexpected_pulse[%0d] edge %0d: got press=%0b release=%0b want none",
                 inst, cyc, pp, rp);
      end else if (p.edge_no != cyc || p.is_press != pp) begin
        errors++;
        $display("FAIL pulse[%0d]: got edge %0d press=%0b want edge %0d press=%0b",
                 inst, cyc, pp, p.edge_no, p.is_press);
      end
    end
    while (front_edge(inst) <= cyc) begin
      pop_exp(inst, have, p);
      checks++;
      errors++;
      $display("FAIL missing_pulse[%0d]: got nothing want press=%0b at edge %0d",
               inst, p.is_press, p.edge_no);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (run_mon) begin
      check_inst(0, lvl0, pp0, rp0);
      check_inst(1, lvl1, pp1, rp1);
    end
  end

  task automatic hold(input bit v, input int n);
    btn_n = v;
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic check_ledg(input string name, input logic [3:0] want);
    checks++;
    if (ledg !== want) begin
      errors++;
      $display("FAIL %s: ledg got %0d want %0d", name, ledg, want);
    end
  endtask

  initial begin
    KEY0  = 1'b0;
    btn_n = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    run_mon = 1'b1;
    KEY0 = 1'b1;
    hold(1'b1, 5);

    // Clean press, then release
    hold(1'b0, 20);
    check_ledg("clean_press", 4'd1);
    hold(1'b1, 20);
    check_ledg("release", 4'd1);

    // Bounce shorter than the debounce window
    hold(1'b0, 3); hold(1'b1, 1); hold(1'b0, 2); hold(1'b1, 12);
    check_ledg("bounce", 4'd1);

    // Long hold with a 2-cycle release glitch (exercises auto-repeat on dut1)
    hold(1'b0, 40); hold(1'b1, 2); hold(1'b0, 30); hold(1'b1, 20);

    // Reset while held; the still-held key must be re-accepted
    hold(1'b0, 20);
    KEY0 = 1'b0;
    hold(1'b0, 2);
    KEY0 = 1'b1;
    hold(1'b0, 20);
    check_ledg("reset_reaccept", 4'd1);
    hold(1'b1, 20);

    // Random runs with occasional resets
    repeat (300) begin
      if ($urandom_range(0, 39) == 0) begin
        KEY0 = 1'b0;
        hold(btn_n, $urandom_range(1, 3));
        KEY0 = 1'b1;
      end
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 8));
    end
    hold(1'b1, 20);

    // Counter hookup: three clean presses
    KEY0 = 1'b0;
    hold(1'b1, 2);
    KEY0 = 1'b1;
    repeat (3) begin
      hold(1'b0, 10);
      hold(1'b1, 10);
    end
    check_ledg("counter_hookup", 4'b0011);

    hold(1'b1, 5);
    checks++;
    if (q0.size() + q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected pulses want 0", q0.size() + q1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
